// File: rtl/sparce_sasa_writer_if.sv
// Request channel into the SASA writer: a valid/ready handshake carrying
// one table address/data pair per accepted beat.
interface sparce_sasa_writer_if;
    typedef logic [31:0] word_t;

    logic  req_valid;
    logic  req_ready;
    word_t req_addr;
    word_t req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/sparce_sasa_writer.sv
// SparCE SASA table programming front end: buffers configuration writes and
// drains them into the table write port while holding lookups off.
module sparce_sasa_writer #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    sparce_sasa_writer_if.slave     req,
    input  logic                    cfg_enable,
    input  logic                    flush,
    output logic [31:0]             sasa_addr,
    output logic [31:0]             sasa_data,
    output logic                    sasa_wen,
    output logic                    sasa_enable,
    output logic                    busy,
    output logic [15:0]             write_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUIESCE = 2'd1,
        WRITE   = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    logic [31:0]      addr_mem_r [DEPTH];
    logic [31:0]      data_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] fifo_count_r;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             req_ready_s;
    logic             push_s;
    logic             pop_s;

    state_t           state_r;
    state_t           state_s;
    logic [SET_W-1:0] settle_r;
    logic [SET_W-1:0] settle_s;
    logic             sasa_wen_r;
    logic             sasa_wen_s;
    logic [31:0]      sasa_addr_r;
    logic [31:0]      sasa_addr_s;
    logic [31:0]      sasa_data_r;
    logic [31:0]      sasa_data_s;
    logic             sasa_enable_r;
    logic             sasa_enable_s;
    logic [15:0]      write_count_r;
    logic [15:0]      write_count_s;

    assign fifo_empty_s  = (fifo_count_r == {CNT_W{1'b0}});
    assign fifo_full_s   = (fifo_count_r == FULL_COUNT);
    // Ready depends only on the registered count and flush, never on req_valid.
    assign req_ready_s   = !fifo_full_s && !flush;
    assign req.req_ready = req_ready_s;
    assign push_s        = req.req_valid && req_ready_s;

    // FIFO pointers and occupancy; flush discards everything buffered.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            fifo_count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1'b1);
                2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1'b1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r] <= req.req_addr;
            data_mem_r[wr_ptr_r] <= req.req_data;
        end
    end

    // Next-state and next-output logic; flush overrides the normal walk.
    always_comb begin
        state_s       = state_r;
        sasa_wen_s    = 1'b0;
        sasa_addr_s   = sasa_addr_r;
        sasa_data_s   = sasa_data_r;
        sasa_enable_s = 1'b0;
        settle_s      = settle_r;
        pop_s         = 1'b0;
        if (flush) begin
            if (state_r == IDLE) begin
                sasa_enable_s = cfg_enable;
            end else begin
                state_s  = SETTLE;
                settle_s = SETTLE_LOAD;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        state_s = QUIESCE;
                    end else begin
                        sasa_enable_s = cfg_enable;
                    end
                end
                QUIESCE, WRITE: begin
                    if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        sasa_wen_s  = 1'b1;
                        sasa_addr_s = addr_mem_r[rd_ptr_r];
                        sasa_data_s = data_mem_r[rd_ptr_r];
                        state_s     = WRITE;
                    end else begin
                        state_s  = SETTLE;
                        settle_s = SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    // A late request rejoins the burst directly; lookups are already off.
                    if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        sasa_wen_s  = 1'b1;
                        sasa_addr_s = addr_mem_r[rd_ptr_r];
                        sasa_data_s = data_mem_r[rd_ptr_r];
                        state_s     = WRITE;
                    end else if (settle_r == {SET_W{1'b0}}) begin
                        state_s       = IDLE;
                        sasa_enable_s = cfg_enable;
                    end else begin
                        settle_s = settle_r - SET_W'(1'b1);
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Saturating count of issued write strobes.
    always_comb begin
        write_count_s = write_count_r;
        if (sasa_wen_s && (write_count_r != 16'hFFFF)) begin
            write_count_s = write_count_r + 16'd1;
        end else begin
            write_count_s = write_count_r;
        end
    end

    // State and registered table-port outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= IDLE;
            settle_r      <= {SET_W{1'b0}};
            sasa_wen_r    <= 1'b0;
            sasa_addr_r   <= 32'h0000_0000;
            sasa_data_r   <= 32'h0000_0000;
            sasa_enable_r <= 1'b0;
            write_count_r <= 16'h0000;
        end else begin
            state_r       <= state_s;
            settle_r      <= settle_s;
            sasa_wen_r    <= sasa_wen_s;
            sasa_addr_r   <= sasa_addr_s;
            sasa_data_r   <= sasa_data_s;
            sasa_enable_r <= sasa_enable_s;
            write_count_r <= write_count_s;
        end
    end

    assign sasa_addr   = sasa_addr_r;
    assign sasa_data   = sasa_data_r;
    assign sasa_wen    = sasa_wen_r;
    assign sasa_enable = sasa_enable_r;
    assign write_count = write_count_r;
    assign busy        = (state_r != IDLE) || !fifo_empty_s;
endmodule

// File: tb/tb_sparce_sasa_writer.sv
// Self-checking bench for sparce_sasa_writer: a DEPTH=4 and a DEPTH=2 instance,
// each with an in-order scoreboard of accepted requests versus issued strobes.
module tb_sparce_sasa_writer;
    logic CLK;
    logic RST;
    logic cfg_enable;
    logic flush;

    logic [31:0] a4_addr, a4_data, a2_addr, a2_data;
    logic        a4_wen, a4_en, a4_busy, a2_wen, a2_en, a2_busy;
    logic [15:0] a4_cnt, a2_cnt;

    int total = 0;
    int bad   = 0;

    logic [63:0] q4 [$];
    logic [63:0] q2 [$];
    logic [63:0] exp4, exp2;

    sparce_sasa_writer_if if4 ();
    sparce_sasa_writer_if if2 ();

    sparce_sasa_writer #(.DEPTH(4), .SETTLE_CYCLES(2)) u_d4 (
        .CLK(CLK), .RST(RST), .req(if4), .cfg_enable(cfg_enable), .flush(flush),
        .sasa_addr(a4_addr), .sasa_data(a4_data), .sasa_wen(a4_wen),
        .sasa_enable(a4_en), .busy(a4_busy), .write_count(a4_cnt)
    );

    sparce_sasa_writer #(.DEPTH(2), .SETTLE_CYCLES(2)) u_d2 (
        .CLK(CLK), .RST(RST), .req(if2), .cfg_enable(cfg_enable), .flush(flush),
        .sasa_addr(a2_addr), .sasa_data(a2_data), .sasa_wen(a2_wen),
        .sasa_enable(a2_en), .busy(a2_busy), .write_count(a2_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Record accepted requests at the edge that accepts them.
    always @(posedge CLK) begin
        if (RST || flush) begin
            q4.delete();
            q2.delete();
        end else begin
            if (if4.req_valid && if4.req_ready) q4.push_back({if4.req_addr, if4.req_data});
            if (if2.req_valid && if2.req_ready) q2.push_back({if2.req_addr, if2.req_data});
        end
    end

    // Every strobe must match the oldest outstanding request.
    always @(negedge CLK) begin
        if (a4_wen) begin
            total++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL sb4_unexpected got=%h_%h exp=none", a4_addr, a4_data);
            end else begin
                exp4 = q4.pop_front();
                if ({a4_addr, a4_data} !== exp4) begin
                    bad++;
                    $display("FAIL sb4_order got=%h_%h exp=%h", a4_addr, a4_data, exp4);
                end
            end
        end
        if (a2_wen) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL sb2_unexpected got=%h_%h exp=none", a2_addr, a2_data);
            end else begin
                exp2 = q2.pop_front();
                if ({a2_addr, a2_data} !== exp2) begin
                    bad++;
                    $display("FAIL sb2_order got=%h_%h exp=%h", a2_addr, a2_data, exp2);
                end
            end
        end
    end

    task automatic drive4(input logic v, input logic [31:0] a, input logic [31:0] d);
        if4.req_valid = v;
        if4.req_addr  = a;
        if4.req_data  = d;
    endtask

    task automatic drive2(input logic v, input logic [31:0] a, input logic [31:0] d);
        if2.req_valid = v;
        if2.req_addr  = a;
        if2.req_data  = d;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        flush = 1'b0;
        cfg_enable = 1'b1;
        drive4(1'b0, 32'h0, 32'h0);
        drive2(1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (!a4_busy && !a2_busy) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_idle_timeout got=busy exp=idle", name);
        end
    endtask

    task automatic test_reset();
        cfg_enable = 1'b1;
        flush = 1'b0;
        drive4(1'b0, 32'h0, 32'h0);
        drive2(1'b0, 32'h0, 32'h0);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if ({a4_wen, a4_en, a4_busy, a4_addr, a4_data, a4_cnt} !== 83'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b%b%b_%h_%h_%h exp=all zero",
                     a4_wen, a4_en, a4_busy, a4_addr, a4_data, a4_cnt);
        end
        total++;
        if (if4.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", if4.req_ready);
        end
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (a4_en !== 1'b1) begin
            bad++;
            $display("FAIL reset_enable_return got=%b exp=1", a4_en);
        end
    endtask

    task automatic test_single();
        do_reset();
        drive4(1'b1, 32'h0000_0010, 32'hA5A5_0003);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 1) drive4(1'b0, 32'h0, 32'h0);
            total++;
            if (a4_en !== ((k >= 2 && k <= 5) ? 1'b0 : 1'b1)) begin
                bad++;
                $display("FAIL single_en k=%0d got=%b", k, a4_en);
            end
            total++;
            if (a4_wen !== ((k == 3) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL single_wen k=%0d got=%b", k, a4_wen);
            end
        end
        total++;
        if (a4_cnt !== 16'd1) begin
            bad++;
            $display("FAIL single_count got=%0d exp=1", a4_cnt);
        end
    endtask

    task automatic test_burst();
        do_reset();
        drive4(1'b1, 32'h0000_0100, 32'hC0DE_0000);
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            if (k < 4) drive4(1'b1, 32'(32'h100 + 4 * k), 32'(32'hC0DE_0000 + k));
            else drive4(1'b0, 32'h0, 32'h0);
            total++;
            if (a4_en !== ((k >= 2 && k <= 8) ? 1'b0 : 1'b1)) begin
                bad++;
                $display("FAIL burst_en k=%0d got=%b", k, a4_en);
            end
            total++;
            if (a4_wen !== ((k >= 3 && k <= 6) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL burst_wen k=%0d got=%b", k, a4_wen);
            end
        end
        total++;
        if (a4_cnt !== 16'd4 || q4.size() != 0) begin
            bad++;
            $display("FAIL burst_count got=%0d left=%0d exp=4 left=0", a4_cnt, q4.size());
        end
    endtask

    task automatic test_full_fifo();
        int   i;
        logic rdy;
        do_reset();
        i = 0;
        drive2(1'b1, 32'h0000_0200, 32'hF00D_0000);
        for (int k = 0; k < 8; k++) begin
            if (if2.req_valid) begin
                total++;
                if (if2.req_ready !== ((k == 2) ? 1'b0 : 1'b1)) begin
                    bad++;
                    $display("FAIL full_ready k=%0d got=%b", k, if2.req_ready);
                end
            end
            rdy = if2.req_valid && if2.req_ready;
            @(negedge CLK);
            if (rdy) i++;
            if (i < 4) drive2(1'b1, 32'(32'h200 + i), 32'(32'hF00D_0000 + i));
            else drive2(1'b0, 32'h0, 32'h0);
        end
        wait_idle("full");
        total++;
        if (a2_cnt !== 16'd4 || q2.size() != 0 || i != 4) begin
            bad++;
            $display("FAIL full_count got=%0d left=%0d sent=%0d exp=4 left=0 sent=4",
                     a2_cnt, q2.size(), i);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive4(1'b1, 32'h0000_0300, 32'hBEEF_0000);
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            if (k < 4) drive4(1'b1, 32'(32'h300 + 4 * k), 32'(32'hBEEF_0000 + k));
            else drive4(1'b0, 32'h0, 32'h0);
            if (k == 5) flush = 1'b0;
            total++;
            if (a4_wen !== ((k == 3 || k == 4) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL flush_wen k=%0d got=%b", k, a4_wen);
            end
            total++;
            if (a4_en !== ((k >= 2 && k <= 6) ? 1'b0 : 1'b1)) begin
                bad++;
                $display("FAIL flush_en k=%0d got=%b", k, a4_en);
            end
            if (k == 4) begin
                flush = 1'b1;
                #1;
                total++;
                if (if4.req_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL flush_ready got=%b exp=0", if4.req_ready);
                end
            end
        end
        total++;
        if (a4_cnt !== 16'd2) begin
            bad++;
            $display("FAIL flush_count got=%0d exp=2", a4_cnt);
        end
    endtask

    task automatic test_settle_reentry();
        do_reset();
        drive4(1'b1, 32'h0000_0400, 32'h1111_0000);
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (k == 4) drive4(1'b1, 32'h0000_0404, 32'h2222_0001);
            else drive4(1'b0, 32'h0, 32'h0);
            total++;
            if (a4_wen !== ((k == 3 || k == 6) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL reentry_wen k=%0d got=%b", k, a4_wen);
            end
            total++;
            if (a4_en !== ((k >= 2 && k <= 8) ? 1'b0 : 1'b1)) begin
                bad++;
                $display("FAIL reentry_en k=%0d got=%b", k, a4_en);
            end
        end
        total++;
        if (a4_cnt !== 16'd2 || q4.size() != 0) begin
            bad++;
            $display("FAIL reentry_count got=%0d left=%0d exp=2 left=0", a4_cnt, q4.size());
        end
    endtask

    task automatic test_enable_tracking();
        logic seq [4];
        seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b1; seq[3] = 1'b0;
        do_reset();
        cfg_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (a4_en !== seq[k]) begin
                bad++;
                $display("FAIL track_en k=%0d got=%b exp=%b", k, a4_en, seq[k]);
            end
            @(negedge CLK);
            cfg_enable = ~cfg_enable;
        end
        cfg_enable = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset_in_write();
        do_reset();
        drive4(1'b1, 32'h0000_0500, 32'h5555_0000);
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            if (k < 4) drive4(1'b1, 32'(32'h500 + 4 * k), 32'(32'h5555_0000 + k));
            else drive4(1'b0, 32'h0, 32'h0);
            if (k == 4) begin
                total++;
                if (a4_wen !== 1'b1) begin
                    bad++;
                    $display("FAIL rstw_pre_wen got=%b exp=1", a4_wen);
                end
                RST = 1'b1;
            end
        end
        total++;
        if ({a4_wen, a4_en, a4_busy, a4_addr, a4_data, a4_cnt} !== 83'd0) begin
            bad++;
            $display("FAIL rstw_outputs got=%b%b%b_%h_%h_%h exp=all zero",
                     a4_wen, a4_en, a4_busy, a4_addr, a4_data, a4_cnt);
        end
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        total++;
        if (a4_busy !== 1'b0 || a4_cnt !== 16'd0 || a4_en !== 1'b1) begin
            bad++;
            $display("FAIL rstw_after got=busy%b cnt%0d en%b exp=busy0 cnt0 en1",
                     a4_busy, a4_cnt, a4_en);
        end
    endtask

    initial begin
        RST = 1'b1;
        flush = 1'b0;
        cfg_enable = 1'b1;
        drive4(1'b0, 32'h0, 32'h0);
        drive2(1'b0, 32'h0, 32'h0);
        test_reset();
        test_single();
        test_burst();
        test_full_fifo();
        test_flush();
        test_settle_reentry();
        test_enable_tracking();
        test_reset_in_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sparce_sasa_writer.md
# sparce_sasa_writer

Programming-side front end for the SparCE SASA table. It accepts configuration writes from the core's CSR/memory-mapped path through a valid/ready port and buffers them in a small FIFO. It drains them into the table's write port (`sasa_addr`, `sasa_data`, `sasa_wen`) one per cycle and owns `sasa_enable`. Lookups are quiesced while entries are being written so the PSRU never consumes a partially programmed table.

## Interface
Parameters:
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `SETTLE_CYCLES`, 2: cycles `sasa_enable` stays low after the last write; ≥1.

Ports:
- `CLK`  in  1  clock.
- `RST`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  write request valid.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_addr`  in  32  SASA table address (`word_t`).
- `req_data`  in  32  SASA table data (`word_t`).
- `cfg_enable`  in  1  software SASA enable bit from CSR.
- `flush`  in  1  discard all buffered requests.
- `sasa_addr`  out  32  table write address, registered.
- `sasa_data`  out  32  table write data, registered.
- `sasa_wen`  out  1  table write strobe, registered, one cycle per entry.
- `sasa_enable`  out  1  table lookup enable, registered.
- `busy`  out  1  `state != IDLE || !fifo_empty`.
- `write_count`  out  16  saturating count of `sasa_wen` pulses.

## Operation
- Reset values: state IDLE, FIFO empty, `sasa_wen` 0, `sasa_addr`/`sasa_data` 0, `sasa_enable` 0, `write_count` 0, settle counter 0.
- FIFO behaviour:
  - `req_ready = !fifo_full & !flush`. There is no bypass; a full FIFO blocks even when a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
- The FSM registers the next-state outputs at each edge:
  - **IDLE**: if the FIFO is non-empty, go to QUIESCE and clear `sasa_enable`. Otherwise `sasa_enable <= cfg_enable`. A non-empty FIFO takes priority over `cfg_enable`.
  - **QUIESCE** (1 cycle, `sasa_enable` = 0): pop the head, `sasa_wen <= 1`, load `sasa_addr`/`sasa_data` from the head, go to WRITE.
  - **WRITE**: if the FIFO is non-empty, pop and register the next write, so strobes are back-to-back. If empty, `sasa_wen <= 0`, load the settle counter with `SETTLE_CYCLES-1`, and go to SETTLE.
  - **SETTLE** (`sasa_enable` = 0, `sasa_wen` = 0):
    - If the FIFO is non-empty, pop, register the write and go to WRITE. There is no re-quiesce.
    - Else if the counter is 0, go to IDLE with `sasa_enable <= cfg_enable`.
    - Else decrement the counter.
- `sasa_enable` is 0 in every state except IDLE.
- `flush` (highest priority after reset):
  - Empties the FIFO.
  - IDLE: stays IDLE.
  - QUIESCE/WRITE: `sasa_wen <= 0`, go to SETTLE with the counter reloaded.
  - SETTLE: the counter is reloaded.
- `write_count` increments on each edge that sets `sasa_wen` and holds at 0xFFFF.
- `cfg_enable` changes during non-IDLE states are ignored until the return to IDLE.

## Timing
- Single request accepted on the edge ending cycle N, starting from IDLE with an empty FIFO:
  - N+1: IDLE sees non-empty.
  - N+2: QUIESCE, `sasa_enable` = 0.
  - N+3: `sasa_wen` = 1 with the request's addr/data.
  - N+4 .. N+3+`SETTLE_CYCLES`: SETTLE.
  - N+4+`SETTLE_CYCLES`: `sasa_enable` = `cfg_enable`.
- Throughput is one table write per cycle.
- `cfg_enable` → `sasa_enable` latency in IDLE is 1 cycle.
- `req_ready` is a function of registered FIFO count plus `flush` only; there is no combinational path from `req_valid`.

## Test plan
- **Single write** (DEPTH=4, S=2, `cfg_enable`=1), addr 0x0000_0010, data 0xA5A5_0003 accepted in cycle N:
  - `sasa_enable` low N+2..N+5.
  - One `sasa_wen` at N+3 with those values.
  - `sasa_enable` high at N+6; `write_count`=1.
- **Back-to-back burst** of 4 requests in N..N+3:
  - `sasa_wen` high N+3..N+6 with entries in order.
  - `sasa_enable` low N+2..N+8.
  - `write_count`=4.
- **Full FIFO** (DEPTH=2): `req_valid` held for 4 requests from N:
  - `req_ready` low in N+2 only.
  - All 4 entries written in order, none lost or duplicated.
- **Flush mid-burst**: 4 requests queued, `flush` in the cycle of the second `sasa_wen`:
  - `sasa_wen` low the next cycle; remaining entries are never written.
  - `sasa_enable` returns after S cycles; `write_count`=2.
- **SETTLE re-entry**: a request accepted in the first SETTLE cycle:
  - Written without QUIESCE.
  - `sasa_enable` stays low continuously until the second settle completes.
- **IDLE enable tracking and reset**:
  - `cfg_enable` 0→1→0 in IDLE: `sasa_enable` follows one cycle later.
  - `RST` asserted in WRITE: all outputs are at reset values the next cycle and FIFO contents are discarded.
